// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: sequential Q16.15 HSV to 8-bit RGB converter built around one shared multiplier.
// Optional build macro HSV2RGB_ROUND_EN: round channels to nearest instead of truncating.
module hsv_to_rgb #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [N-1:0] H,
  input  logic [N-1:0] S,
  input  logic [N-1:0] V,
  output logic [7:0]   R,
  output logic [7:0]   G,
  output logic [7:0]   B,
  output logic         o_busy,
  output logic         o_complete
);
  // state | meaning
  // IDLE  | waiting for i_start; inputs conditioned and captured on start
  // SECT  | sector and remainder select, C = V*S
  // FRAC  | position within sector g, offset m = V - C
  // MULX  | X = C*g
  // OUT   | channel mapping, 8-bit conversion, completion pulse
  typedef enum logic [2:0] {IDLE, SECT, FRAC, MULX, OUT} state_t;

  localparam int           FW     = 15;
  localparam logic [N-1:0] ONE    = N'(1) << FW;
  localparam logic [N-1:0] DEG60  = N'(60) << FW;
  localparam logic [N-1:0] DEG120 = N'(120) << FW;
  localparam logic [N-1:0] DEG180 = N'(180) << FW;
  localparam logic [N-1:0] DEG240 = N'(240) << FW;
  localparam logic [N-1:0] DEG300 = N'(300) << FW;
  localparam logic [N-1:0] DEG360 = N'(360) << FW;
  localparam logic [N-1:0] VMAX   = N'(255) << FW;
  localparam logic [N-1:0] INV60  = N'(34953);
`ifdef HSV2RGB_ROUND_EN
  localparam logic [N:0]   RND    = (N+1)'(1) << (FW - 1);
`else
  localparam logic [N:0]   RND    = '0;
`endif

  state_t         state_q;
  logic [N-1:0]   h_q, s_q, v_q, rem_q, c_q, m_q, x_q;
  logic [2:0]     sector_q;
  logic [15:0]    gfac_q;
  logic [7:0]     r_q, g_q, b_q;
  logic           busy_q, done_q;

  logic [N-1:0]   h_mag, h_cond, s_cond, v_cond;
  logic [2:0]     sector_d;
  logic [N-1:0]   base_d;
  logic [N-1:0]   mul_a, mul_b;
  logic [2*N-1:0] prod;
  logic [15:0]    f_d;
  logic [N-1:0]   ch_r, ch_g, ch_b;

  function automatic logic [7:0] to_u8(input logic [N-1:0] val);
    logic [N:0] t;
    t = ({1'b0, val} + RND) >> FW;
    return (|t[N:8]) ? 8'hFF : t[7:0];
  endfunction

  always_comb begin
    h_mag  = H[N-1] ? '0 : H;
    h_cond = h_mag;
    if (h_mag >= DEG360) begin
      h_cond = h_mag - DEG360;
      if (h_cond >= DEG360) h_cond = '0;
    end
    s_cond = S[N-1] ? '0 : S;
    if (s_cond > ONE) s_cond = ONE;
    v_cond = V[N-1] ? '0 : V;
    if (v_cond > VMAX) v_cond = VMAX;
  end

  always_comb begin
    sector_d = 3'd0;
    base_d   = '0;
    if (h_q >= DEG300) begin
      sector_d = 3'd5; base_d = DEG300;
    end else if (h_q >= DEG240) begin
      sector_d = 3'd4; base_d = DEG240;
    end else if (h_q >= DEG180) begin
      sector_d = 3'd3; base_d = DEG180;
    end else if (h_q >= DEG120) begin
      sector_d = 3'd2; base_d = DEG120;
    end else if (h_q >= DEG60) begin
      sector_d = 3'd1; base_d = DEG60;
    end
  end

  // One multiplier, operands selected by the schedule step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      SECT:    begin mul_a = v_q;   mul_b = s_q;              end
      FRAC:    begin mul_a = rem_q; mul_b = INV60;            end
      MULX:    begin mul_a = c_q;   mul_b = N'(gfac_q);       end
      default: begin mul_a = '0;    mul_b = '0;               end
    endcase
    prod = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
    f_d  = 16'(prod >> (FW + 6));
  end

  always_comb begin
    ch_r = m_q;
    ch_g = m_q;
    ch_b = m_q;
    case (sector_q)
      3'd0:    begin ch_r = c_q + m_q; ch_g = x_q + m_q; end
      3'd1:    begin ch_r = x_q + m_q; ch_g = c_q + m_q; end
      3'd2:    begin ch_g = c_q + m_q; ch_b = x_q + m_q; end
      3'd3:    begin ch_g = x_q + m_q; ch_b = c_q + m_q; end
      3'd4:    begin ch_r = x_q + m_q; ch_b = c_q + m_q; end
      default: begin ch_r = c_q + m_q; ch_b = x_q + m_q; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h_q      <= '0;
      s_q      <= '0;
      v_q      <= '0;
      rem_q    <= '0;
      c_q      <= '0;
      m_q      <= '0;
      x_q      <= '0;
      sector_q <= 3'd0;
      gfac_q   <= 16'd0;
      r_q      <= 8'd0;
      g_q      <= 8'd0;
      b_q      <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            h_q     <= h_cond;
            s_q     <= s_cond;
            v_q     <= v_cond;
            busy_q  <= 1'b1;
            state_q <= SECT;
          end
        end
        SECT: begin
          sector_q <= sector_d;
          rem_q    <= h_q - base_d;
          c_q      <= N'(prod >> FW);
          state_q  <= FRAC;
        end
        FRAC: begin
          // Odd sectors ramp down, so g counts from the far edge.
          gfac_q  <= sector_q[0] ? (16'd32768 - f_d) : f_d;
          m_q     <= v_q - c_q;
          state_q <= MULX;
        end
        MULX: begin
          x_q     <= N'(prod >> FW);
          state_q <= OUT;
        end
        OUT: begin
          r_q     <= to_u8(ch_r);
          g_q     <= to_u8(ch_g);
          b_q     <= to_u8(ch_b);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign R          = r_q;
  assign G          = g_q;
  assign B          = b_q;
  assign o_busy     = busy_q;
  assign o_complete = done_q;

endmodule

// File: tb/tb_hsv_to_rgb.sv
// tb_hsv_to_rgb: directed and randomized checks of hsv_to_rgb against an arithmetic reference model.
// Honours HSV2RGB_ROUND_EN the same way the design does.
module tb_hsv_to_rgb;
  localparam int Q = 32768;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] H = '0, S = '0, V = '0;
  logic [7:0]  R, G, B;
  logic        o_busy, o_complete;

  int n_vec  = 0;
  int n_miss = 0;

  // Per sector: what drives (R,G,B); 2 = C, 1 = X, 0 = zero.
  int chmap [6][3] = '{'{2, 1, 0}, '{1, 2, 0}, '{0, 2, 1},
                       '{0, 1, 2}, '{1, 0, 2}, '{2, 0, 1}};

  always #5 clk = ~clk;

  hsv_to_rgb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .H          (H),
    .S          (S),
    .V          (V),
    .R          (R),
    .G          (G),
    .B          (B),
    .o_busy     (o_busy),
    .o_complete (o_complete)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [31:0] h, input logic [31:0] s, input logic [31:0] v);
    longint hh, ss, vv, c, f, g, x, m, rem, val;
    int sec;
    logic [7:0] ch [3];
    hh = h[31] ? 0 : longint'(h);
    if (hh >= 360 * Q) hh = hh - 360 * Q;
    if (hh >= 360 * Q) hh = 0;
    ss = s[31] ? 0 : longint'(s);
    if (ss > Q) ss = Q;
    vv = v[31] ? 0 : longint'(v);
    if (vv > 255 * Q) vv = 255 * Q;
    sec = int'(hh / (60 * Q));
    rem = hh - longint'(sec) * 60 * Q;
    c = (vv * ss) / Q;
    f = (rem * 34953) / (64 * Q);
    g = (sec % 2 == 1) ? Q - f : f;
    x = (c * g) / Q;
    m = vv - c;
    for (int k = 0; k < 3; k++) begin
      val = (chmap[sec][k] == 2) ? c : (chmap[sec][k] == 1) ? x : 0;
      val = val + m;
`ifdef HSV2RGB_ROUND_EN
      val = val + Q / 2;
`endif
      val = val / Q;
      if (val > 255) val = 255;
      ch[k] = 8'(val);
    end
    return {ch[0], ch[1], ch[2]};
  endfunction

  // Launch one conversion and watch 8 edges after the start edge.
  task automatic convert(input logic [31:0] h, input logic [31:0] s, input logic [31:0] v,
                         input bit hold, output int lat, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    H = h; S = s; V = v; i_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      i_start = 1'b0;
      H = $urandom; S = $urandom; V = $urandom;
    end
    lat = -1; busy_cnt = 0; done_cnt = 0;
    if (o_busy) busy_cnt++;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (o_complete) begin
        done_cnt++;
        if (lat < 0) lat = i;
      end
      if (o_busy) busy_cnt++;
      if (hold && i == 4) i_start = 1'b0;
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] h, input logic [31:0] s,
                          input logic [31:0] v, input int er, input int eg, input int eb);
    int lat, bc, dc;
    convert(h, s, v, 1'b0, lat, bc, dc);
    check({tag, ".R"}, R, er);
    check({tag, ".G"}, G, eg);
    check({tag, ".B"}, B, eb);
  endtask

  initial begin
    int lat, bc, dc;
    logic [31:0] h, s, v;
    logic [23:0] exp;

    #3 rst_n = 1'b0;
    #1;
    check("reset.R", R, 0);
    check("reset.G", G, 0);
    check("reset.B", B, 0);
    check("reset.busy", o_busy, 0);
    check("reset.complete", o_complete, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    convert(32'd0, Q, 255 * Q, 1'b0, lat, bc, dc);
    check("basic.latency", lat, 4);
    check("basic.busy_cycles", bc, 4);
    check("basic.completes", dc, 1);
    check("basic.R", R, 255);
    check("basic.G", G, 0);
    check("basic.B", B, 0);

    directed("h120", 120 * Q, Q, 255 * Q, 0, 255, 0);
    directed("h240", 240 * Q, Q, 255 * Q, 0, 0, 255);
    directed("h360", 360 * Q, Q, 255 * Q, 255, 0, 0);
    directed("grey", 200 * Q, 0, 128 * Q, 128, 128, 128);
`ifdef HSV2RGB_ROUND_EN
    directed("round30", 30 * Q, Q, 255 * Q, 255, 128, 0);
    directed("h400", 400 * Q, Q, 255 * Q, 255, 170, 0);
`else
    directed("round30", 30 * Q, Q, 255 * Q, 255, 127, 0);
    directed("h400", 400 * Q, Q, 255 * Q, 255, 169, 0);
`endif
    directed("hneg", 32'h8000_0000 | (10 * Q), Q, 255 * Q, 255, 0, 0);
    directed("h800", 800 * Q, Q, 255 * Q, 255, 0, 0);

    exp = model(100 * Q, Q, 255 * Q);
    directed("s2", 100 * Q, 2 * Q, 255 * Q, int'(exp[23:16]), int'(exp[15:8]), int'(exp[7:0]));

    convert(150 * Q, Q, 200 * Q, 1'b1, lat, bc, dc);
    exp = model(150 * Q, Q, 200 * Q);
    check("hold.completes", dc, 1);
    check("hold.latency", lat, 4);
    check("hold.R", R, exp[23:16]);
    check("hold.G", G, exp[15:8]);
    check("hold.B", B, exp[7:0]);

    // Abort during MULX: outputs were nonzero from the previous conversion.
    @(negedge clk);
    H = 50 * Q; S = Q; V = 255 * Q; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort.R", R, 0);
    check("abort.G", G, 0);
    check("abort.B", B, 0);
    check("abort.busy", o_busy, 0);
    check("abort.complete", o_complete, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_complete) dc++;
    end
    check("abort.no_complete", dc, 0);
    directed("after_rst", 120 * Q, Q, 255 * Q, 0, 255, 0);

    for (int n = 0; n < 40; n++) begin
      h = $urandom_range(0, 800 * Q);
      if ($urandom_range(0, 7) == 0) h[31] = 1'b1;
      s = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 2 * Q);
      v = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 300 * Q);
      exp = model(h, s, v);
      convert(h, s, v, 1'b0, lat, bc, dc);
      check("rand.latency", lat, 4);
      check("rand.R", R, exp[23:16]);
      check("rand.G", G, exp[15:8]);
      check("rand.B", B, exp[7:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
